// File: rtl/keypad_digit_entry.sv
// Keypad digit entry: assembles BCD digits from debounced key events and commits them with a valid/ack handshake.
// Optional idle auto-clear is enabled by defining KEYPAD_ENTRY_TIMEOUT_EN.
module keypad_digit_entry #(
  parameter int NUM_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              key_code,
  input  logic                    key_pressed,
  input  logic                    value_ack,
  output logic [4*NUM_DIGITS-1:0] disp_digits,
  output logic [2:0]              digit_count,
  output logic [4*NUM_DIGITS-1:0] value_out,
  output logic                    value_valid,
  output logic                    entry_err
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam logic [2:0] MAX_CNT = 3'(NUM_DIGITS);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ENTRY = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t state_r;
  logic   press_d_r;
  logic   key_evt_s;
  logic   is_digit_s;
  logic   timeout_s;

  // Rising edge of the debounced press level; holding a key yields one event.
  always_comb begin
    key_evt_s  = key_pressed & ~press_d_r;
    is_digit_s = (key_code <= 4'd9);
  end

`ifdef KEYPAD_ENTRY_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] idle_r;

  // Idle counter runs only while a partial entry is pending and no key arrives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_r <= '0;
    end else if ((state_r != ST_ENTRY) || key_evt_s) begin
      idle_r <= '0;
    end else if (idle_r == IDLE_LAST) begin
      idle_r <= '0;
    end else begin
      idle_r <= idle_r + TW'(1);
    end
  end

  // A key event in the same cycle takes priority over the timeout.
  always_comb begin
    if ((state_r == ST_ENTRY) && !key_evt_s && (idle_r == IDLE_LAST)) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end
`else
  // Entry persists indefinitely in the default build.
  always_comb begin
    timeout_s = 1'b0;
  end
`endif

  // Entry FSM with registered display, commit and error outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_EMPTY;
      press_d_r   <= 1'b0;
      disp_digits <= '0;
      digit_count <= 3'd0;
      value_out   <= '0;
      value_valid <= 1'b0;
      entry_err   <= 1'b0;
    end else begin
      press_d_r <= key_pressed;
      entry_err <= 1'b0;
      case (state_r)
        ST_EMPTY: begin
          if (key_evt_s) begin
            if (is_digit_s) begin
              disp_digits <= (disp_digits << 4) | BW'(key_code);
              digit_count <= 3'd1;
              state_r     <= ST_ENTRY;
            end else if (key_code == 4'd13) begin
              entry_err <= 1'b1;
            end else if (key_code == 4'd10) begin
              disp_digits <= '0;
              digit_count <= 3'd0;
            end else begin
              state_r <= ST_EMPTY;
            end
          end else begin
            state_r <= ST_EMPTY;
          end
        end
        ST_ENTRY: begin
          if (key_evt_s) begin
            if (is_digit_s) begin
              if (digit_count < MAX_CNT) begin
                disp_digits <= (disp_digits << 4) | BW'(key_code);
                digit_count <= digit_count + 3'd1;
              end else begin
                entry_err <= 1'b1;
              end
            end else if (key_code == 4'd11) begin
              disp_digits <= disp_digits >> 4;
              digit_count <= digit_count - 3'd1;
              if (digit_count == 3'd1) begin
                state_r <= ST_EMPTY;
              end else begin
                state_r <= ST_ENTRY;
              end
            end else if (key_code == 4'd10) begin
              disp_digits <= '0;
              digit_count <= 3'd0;
              state_r     <= ST_EMPTY;
            end else if (key_code == 4'd13) begin
              value_out   <= disp_digits;
              value_valid <= 1'b1;
              disp_digits <= '0;
              digit_count <= 3'd0;
              state_r     <= ST_HOLD;
            end else begin
              state_r <= ST_ENTRY;
            end
          end else if (timeout_s) begin
            disp_digits <= '0;
            digit_count <= 3'd0;
            entry_err   <= 1'b1;
            state_r     <= ST_EMPTY;
          end else begin
            state_r <= ST_ENTRY;
          end
        end
        ST_HOLD: begin
          // Keys are dropped while a commit is outstanding, even on the ack cycle.
          if (value_ack) begin
            value_valid <= 1'b0;
            state_r     <= ST_EMPTY;
          end else begin
            state_r <= ST_HOLD;
          end
        end
        default: begin
          disp_digits <= '0;
          digit_count <= 3'd0;
          value_valid <= 1'b0;
          state_r     <= ST_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_digit_entry.sv
// Scoreboard bench for keypad_digit_entry: stimulus queues expectations, monitors pop and compare.
`timescale 1ns/1ps
module tb_keypad_digit_entry;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  key_code = 4'd15;
  logic        key_pressed = 1'b0;
  logic        value_ack = 1'b0;
  logic [15:0] disp_digits;
  logic [2:0]  digit_count;
  logic [15:0] value_out;
  logic        value_valid;
  logic        entry_err;

  typedef struct {
    string       name;
    logic [15:0] disp;
    logic [2:0]  cnt;
    logic        valid;
    logic [15:0] vout;
  } snap_t;

  snap_t       snap_q[$];
  logic [15:0] commit_q[$];
  string       err_q[$];
  logic        strobe = 1'b0;
  logic        prev_valid = 1'b0;
  int          total = 0;
  int          bad = 0;

`ifdef KEYPAD_ENTRY_TIMEOUT_EN
  keypad_digit_entry #(.NUM_DIGITS(4), .TIMEOUT_CYCLES(16)) dut (
`else
  keypad_digit_entry #(.NUM_DIGITS(4)) dut (
`endif
    .clk(clk), .rst(rst), .key_code(key_code), .key_pressed(key_pressed),
    .value_ack(value_ack), .disp_digits(disp_digits), .digit_count(digit_count),
    .value_out(value_out), .value_valid(value_valid), .entry_err(entry_err));

  always #5 clk = ~clk;

  // Snapshot monitor: compares the live state whenever the stimulus strobes.
  always @(negedge clk) begin
    if (strobe) begin
      snap_t s;
      s = snap_q.pop_front();
      total++;
      if (disp_digits !== s.disp || digit_count !== s.cnt ||
          value_valid !== s.valid || value_out !== s.vout) begin
        bad++;
        $display("FAIL %s: got disp=%h cnt=%0d valid=%b vout=%h, want disp=%h cnt=%0d valid=%b vout=%h",
                 s.name, disp_digits, digit_count, value_valid, value_out,
                 s.disp, s.cnt, s.valid, s.vout);
      end
    end
  end

  // Commit monitor: each rising value_valid must match the next queued commit.
  always @(negedge clk) begin
    if (value_valid && !prev_valid) begin
      total++;
      if (commit_q.size() == 0) begin
        bad++;
        $display("FAIL commit_unexpected: got value_out=%h, want no commit", value_out);
      end else begin
        logic [15:0] e;
        e = commit_q.pop_front();
        if (value_out !== e) begin
          bad++;
          $display("FAIL commit_value: got %h, want %h", value_out, e);
        end
      end
    end
    prev_valid = value_valid;
  end

  // Error monitor: every cycle entry_err is high consumes one expected rejection.
  always @(negedge clk) begin
    if (entry_err === 1'b1) begin
      total++;
      if (err_q.size() == 0) begin
        bad++;
        $display("FAIL err_unexpected: got entry_err=1, want 0");
      end else begin
        void'(err_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] c, input int hold = 1);
    key_code = c;
    key_pressed = 1'b1;
    repeat (hold) tick();
    key_pressed = 1'b0;
    tick();
  endtask

  task automatic check(input string n, input logic [15:0] d, input logic [2:0] c,
                       input logic v, input logic [15:0] vo);
    snap_t s;
    s.name = n; s.disp = d; s.cnt = c; s.valid = v; s.vout = vo;
    snap_q.push_back(s);
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
  endtask

  initial begin
    tick(); tick();
    check("reset", 16'h0000, 3'd0, 1'b0, 16'h0000);
    rst = 1'b1;
    tick();

    // Basic entry and commit
    key(4'd1); key(4'd2); key(4'd3);
    check("t1_entry", 16'h0123, 3'd3, 1'b0, 16'h0000);
    commit_q.push_back(16'h0123);
    key(4'd13);
    check("t1_commit", 16'h0000, 3'd0, 1'b1, 16'h0123);
    tick(); tick();
    check("t1_hold", 16'h0000, 3'd0, 1'b1, 16'h0123);
    value_ack = 1'b1; tick(); value_ack = 1'b0; tick();
    check("t1_acked", 16'h0000, 3'd0, 1'b0, 16'h0123);

    // Overflow
    key(4'd9); key(4'd8); key(4'd7); key(4'd6);
    check("t2_full", 16'h9876, 3'd4, 1'b0, 16'h0123);
    err_q.push_back("overflow");
    key(4'd5);
    check("t2_overflow", 16'h9876, 3'd4, 1'b0, 16'h0123);
    key(4'd10);
    check("t2_clear", 16'h0000, 3'd0, 1'b0, 16'h0123);

    // Backspace down to empty and beyond
    key(4'd4); key(4'd5);
    check("t3_45", 16'h0045, 3'd2, 1'b0, 16'h0123);
    key(4'd11);
    check("t3_bs1", 16'h0004, 3'd1, 1'b0, 16'h0123);
    key(4'd11);
    check("t3_bs2", 16'h0000, 3'd0, 1'b0, 16'h0123);
    key(4'd11);
    check("t3_bs3", 16'h0000, 3'd0, 1'b0, 16'h0123);

    // Keys in HOLD, then ack coinciding with a key edge
    key(4'd7);
    commit_q.push_back(16'h0007);
    key(4'd13);
    key(4'd3);
    check("t4_hold_key", 16'h0000, 3'd0, 1'b1, 16'h0007);
    key_code = 4'd5; key_pressed = 1'b1; value_ack = 1'b1;
    tick();
    value_ack = 1'b0; key_pressed = 1'b0;
    tick();
    check("t4_ack_key", 16'h0000, 3'd0, 1'b0, 16'h0007);
    key(4'd3);
    check("t4_after", 16'h0003, 3'd1, 1'b0, 16'h0007);
    key(4'd10);

    // Held key, ignored codes, empty enter
    key(4'd2, 50);
    check("t5_held", 16'h0002, 3'd1, 1'b0, 16'h0007);
    key(4'd12); key(4'd14); key(4'd15);
    check("t5_ignored", 16'h0002, 3'd1, 1'b0, 16'h0007);
    key(4'd11);
    err_q.push_back("empty_enter");
    key(4'd13);
    check("t5_empty_enter", 16'h0000, 3'd0, 1'b0, 16'h0007);

    // Reset with a commit pending
    key(4'd8); key(4'd9);
    commit_q.push_back(16'h0089);
    key(4'd13);
    check("t6_pending", 16'h0000, 3'd0, 1'b1, 16'h0089);
    #2 rst = 1'b0;
    #1;
    check("t6_reset", 16'h0000, 3'd0, 1'b0, 16'h0000);
    rst = 1'b1;
    tick();
    key(4'd6);
    check("t6_reset_entry", 16'h0006, 3'd1, 1'b0, 16'h0000);
    #2 rst = 1'b0;
    #1;
    check("t6_reset_mid", 16'h0000, 3'd0, 1'b0, 16'h0000);
    rst = 1'b1;
    tick();

`ifdef KEYPAD_ENTRY_TIMEOUT_EN
    // Idle timeout: clears on the 16th edge after the key edge
    err_q.push_back("timeout");
    key_code = 4'd5; key_pressed = 1'b1;
    tick();
    key_pressed = 1'b0;
    repeat (15) tick();
    check("t7_before_to", 16'h0005, 3'd1, 1'b0, 16'h0000);
    check("t7_after_to", 16'h0000, 3'd0, 1'b0, 16'h0000);
`endif

    tick(); tick();
    total++;
    if (err_q.size() != 0) begin
      bad++;
      $display("FAIL err_missing: got %0d unseen rejections, want 0", err_q.size());
    end
    total++;
    if (commit_q.size() != 0) begin
      bad++;
      $display("FAIL commit_missing: got %0d unseen commits, want 0", commit_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
